// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: access sizes, branch conditions,
// request FSM encoding and lane helpers.
package mem_access_stage_pkg;

  localparam int XLEN_W = 64;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return off[0] == 1'b0;
      SZ_WORD: return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 8'h01;
      SZ_HALF: return 8'h03;
      SZ_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Copies the low bytes of the store value into every lane of that size,
  // so the byte enables alone pick the destination lane.
  function automatic logic [63:0] lane_replicate(input logic [1:0] sz, input logic [63:0] d);
    case (sz)
      SZ_BYTE: return {8{d[7:0]}};
      SZ_HALF: return {4{d[15:0]}};
      SZ_WORD: return {2{d[31:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load data alignment: selects the addressed lane of the memory word and
// sign- or zero-extends it to XLEN.
module load_extend
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = XLEN_W
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;
  logic            uns;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    uns     = funct3[2];
    case (funct3[1:0])
      SZ_BYTE: data = uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                          : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                          : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_WORD: data = uns ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                          : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: branch resolution, data-memory handshake with pipeline stall,
// and the MEM/WB boundary register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = XLEN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] addsum,
  input  logic [XLEN-1:0] alures,
  input  logic            zero,
  input  logic            is_greater,
  input  logic [XLEN-1:0] rd2,
  input  logic [4:0]      rd,
  input  logic            regwrite,
  input  logic            memtoreg,
  input  logic            branch,
  input  logic            memread,
  input  logic            memwrite,
  input  logic [3:0]      func,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic            flush,
  output logic            misalign_err,
  output logic            wb_regwrite,
  output logic            wb_memtoreg,
  output logic [XLEN-1:0] wb_readdata,
  output logic [XLEN-1:0] wb_alures,
  output logic [4:0]      wb_rd
);

  state_t          state, state_nxt;
  logic            mem_op, aligned, take, start;
  logic [XLEN-1:0] ext_data;
  logic            unused_funct7;

  logic [4:0]      rd_p1;
  logic            regwrite_p1, memtoreg_p1, memread_p1;
  logic [2:0]      funct3_p1;
  logic [XLEN-1:0] alures_p1;

  assign mem_op        = memread | memwrite;
  assign aligned       = is_aligned(func[1:0], alures[2:0]);
  assign start         = (state == IDLE) && mem_op && aligned;
  assign branch_target = addsum;
  assign flush         = pc_src;
  assign unused_funct7 = func[3];

  always_comb begin
    take = 1'b0;
    case (func[2:0])
      F3_BEQ:  take = zero;
      F3_BNE:  take = !zero;
      F3_BLT:  take = !zero && !is_greater;
      F3_BGE:  take = zero || is_greater;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    pc_src    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end else if (branch && !mem_op) begin
          pc_src = take;
        end
      end
      REQ: begin
        stall = !dmem_ready;
        if (dmem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Combinational outputs are forced low while reset is asserted.
    if (!rst_n) begin
      stall  = 1'b0;
      pc_src = 1'b0;
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata  (dmem_rdata),
    .lane   (alures_p1[2:0]),
    .funct3 (funct3_p1),
    .data   (ext_data)
  );

  // ---- p1: request context captured at issue, consumed at completion ----
  always_ff @(posedge clk) begin
    if (start) begin
      rd_p1       <= rd;
      regwrite_p1 <= regwrite;
      memtoreg_p1 <= memtoreg;
      memread_p1  <= memread;
      funct3_p1   <= func[2:0];
      alures_p1   <= alures;
    end
  end

  // ---- MEM/WB boundary and memory request registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      misalign_err <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_readdata  <= '0;
      wb_alures    <= '0;
      wb_rd        <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dmem_req    <= 1'b1;
            dmem_we     <= memwrite;
            dmem_addr   <= {alures[XLEN-1:3], 3'b000};
            dmem_be     <= size_mask(func[1:0]) << alures[2:0];
            dmem_wdata  <= lane_replicate(func[1:0], rd2);
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_rd       <= '0;
          end else begin
            // Plain ALU/branch ops pass straight through; a misaligned
            // access lands here too but never writes the register file.
            misalign_err <= mem_op;
            wb_regwrite  <= regwrite & ~mem_op;
            wb_memtoreg  <= memtoreg;
            wb_rd        <= rd;
            wb_alures    <= alures;
            wb_readdata  <= '0;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            dmem_req    <= 1'b0;
            wb_regwrite <= regwrite_p1;
            wb_memtoreg <= memtoreg_p1;
            wb_rd       <= rd_p1;
            wb_alures   <= alures_p1;
            wb_readdata <= memread_p1 ? ext_data : '0;
          end else begin
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_rd       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised scoreboard bench for mem_access_stage with a byte-addressed
// reference memory model and an independent memory responder.
module tb_mem_access_stage;

  logic        clk, rst_n;
  logic [63:0] addsum, alures, rd2;
  logic        zero, is_greater;
  logic [4:0]  rd;
  logic        regwrite, memtoreg, branch, memread, memwrite;
  logic [3:0]  func;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;
  logic        stall, pc_src, flush, misalign_err;
  logic [63:0] branch_target;
  logic        wb_regwrite, wb_memtoreg;
  logic [63:0] wb_readdata, wb_alures;
  logic [4:0]  wb_rd;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .addsum(addsum), .alures(alures), .zero(zero),
    .is_greater(is_greater), .rd2(rd2), .rd(rd), .regwrite(regwrite),
    .memtoreg(memtoreg), .branch(branch), .memread(memread), .memwrite(memwrite),
    .func(func), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .flush(flush), .misalign_err(misalign_err),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_readdata(wb_readdata),
    .wb_alures(wb_alures), .wb_rd(wb_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [63:0] addsum, alures, rd2;
    logic        zero, gt, regwrite, memtoreg, branch, memread, memwrite;
    logic [4:0]  rd;
    logic [3:0]  func;
  } instr_t;

  typedef struct packed {
    logic        regwrite, memtoreg, misal, chk_rdata;
    logic [4:0]  rd;
    logic [63:0] alures, readdata;
  } wb_t;

  typedef struct packed {
    logic [63:0] addr, wdata;
    logic        we;
    logic [7:0]  be;
  } req_t;

  wb_t  exp_wb[$];
  req_t exp_req[$];
  logic [7:0] ref_mem [logic [63:0]];
  logic [7:0] dev_mem [logic [63:0]];

  int n_vec = 0;
  int n_err = 0;
  int force_wait = -1;
  bit mon_en = 1'b0;
  bit pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (got none, required one)", name);
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  function automatic logic [7:0] dflt_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt_byte(a);
  endfunction

  function automatic logic [7:0] dev_rd(input logic [63:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt_byte(a);
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input instr_t t);
    addsum = t.addsum; alures = t.alures; rd2 = t.rd2; zero = t.zero;
    is_greater = t.gt; rd = t.rd; regwrite = t.regwrite; memtoreg = t.memtoreg;
    branch = t.branch; memread = t.memread; memwrite = t.memwrite; func = t.func;
  endtask

  // Reference model: computes the architectural outcome of one instruction.
  task automatic issue(input instr_t t, input int exp_stall);
    wb_t w;
    req_t r;
    int n, cnt;
    logic [2:0] off;
    logic [63:0] v, mask;
    logic mem, taken, exp_pc;
    bit done;
    n   = 1 << t.func[1:0];
    off = t.alures[2:0];
    mem = t.memread | t.memwrite;
    w.regwrite = t.regwrite; w.memtoreg = t.memtoreg; w.rd = t.rd;
    w.alures = t.alures; w.readdata = '0; w.misal = 1'b0; w.chk_rdata = 1'b1;
    r = '0;
    if (mem && ((t.alures % n) != 0)) begin
      w.regwrite = 1'b0; w.misal = 1'b1; w.chk_rdata = 1'b0;
    end else if (mem) begin
      r.addr = {t.alures[63:3], 3'b000};
      r.be   = 8'(((1 << n) - 1) << off);
      r.we   = t.memwrite;
      if (t.memread) begin
        v = '0;
        for (int i = 0; i < n; i++) v |= 64'(ref_rd(t.alures + 64'(i))) << (8 * i);
        mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        if (!t.func[2] && n < 8 && v[8*n-1]) v |= ~mask;
        w.readdata = v;
      end else begin
        w.chk_rdata = 1'b0;
        for (int i = 0; i < n; i++) begin
          r.wdata[(int'(off) + i) * 8 +: 8] = t.rd2[i*8 +: 8];
          ref_mem[t.alures + 64'(i)] = t.rd2[i*8 +: 8];
        end
      end
      exp_req.push_back(r);
    end
    exp_wb.push_back(w);
    case (t.func[2:0])
      3'b000:  taken = t.zero;
      3'b001:  taken = !t.zero;
      3'b100:  taken = !t.zero && !t.gt;
      3'b101:  taken = t.zero || t.gt;
      default: taken = 1'b0;
    endcase
    exp_pc = t.branch && !mem && taken;
    drive(t);
    cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("pc_src", pc_src, exp_pc);
        check("flush", flush, exp_pc);
        if (exp_pc) check("branch_target", branch_target, t.addsum);
      end
      if (!stall) begin
        done = 1'b1;
        break;
      end
      cnt++;
    end
    if (!done) begin
      fail_event("stall_timeout");
      finish_run();
    end
    if (exp_stall >= 0) check("stall_cycles", cnt, exp_stall);
    if (!mem) check("dmem_req_idle", dmem_req, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one MEM/WB result per instruction accepted (stall low at an edge).
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (pending) begin
        if (exp_wb.size() == 0) begin
          fail_event("wb_unexpected");
        end else begin
          w = exp_wb.pop_front();
          check("wb_regwrite", wb_regwrite, w.regwrite);
          check("wb_alures", wb_alures, w.alures);
          check("misalign_err", misalign_err, w.misal);
          if (w.regwrite) begin
            check("wb_rd", wb_rd, w.rd);
            check("wb_memtoreg", wb_memtoreg, w.memtoreg);
          end
          if (w.chk_rdata) check("wb_readdata", wb_readdata, w.readdata);
        end
      end
      pending = mon_en && rst_n && !stall;
    end
  end

  // Memory responder with its own storage and random wait states.
  initial begin
    req_t r;
    int w;
    bit aborted;
    logic [63:0] a, d;
    logic [7:0] be;
    logic we;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && dmem_req) begin
        a = dmem_addr; d = dmem_wdata; be = dmem_be; we = dmem_we;
        if (exp_req.size() == 0) begin
          fail_event("dmem_req_unexpected");
        end else begin
          r = exp_req.pop_front();
          check("dmem_addr", a, r.addr);
          check("dmem_we", we, r.we);
          check("dmem_be", be, r.be);
          if (r.we)
            for (int l = 0; l < 8; l++)
              if (r.be[l]) check("dmem_wdata_lane", d[l*8 +: 8], r.wdata[l*8 +: 8]);
        end
        w = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        aborted = 1'b0;
        for (int i = 0; i < w; i++) begin
          @(posedge clk);
          #1;
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          for (int l = 0; l < 8; l++) dmem_rdata[l*8 +: 8] = dev_rd(a + 64'(l));
          dmem_ready = 1'b1;
          @(posedge clk);
          #1;
          dmem_ready = 1'b0;
          if (we)
            for (int l = 0; l < 8; l++)
              if (be[l]) dev_mem[a + 64'(l)] = d[l*8 +: 8];
        end else begin
          // A stray completion after reset must be ignored by the stage.
          wait (rst_n);
          @(posedge clk);
          #1;
          dmem_rdata = r64();
          dmem_ready = 1'b1;
          repeat (3) begin
            @(posedge clk);
            #1;
          end
          dmem_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    instr_t t;
    req_t r;
    bit got;
    int kind, off;
    logic [1:0] sz;
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_dmem_req", dmem_req, 0);     check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);   check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_dmem_be", dmem_be, 0);       check("rst_stall", stall, 0);
    check("rst_pc_src", pc_src, 0);         check("rst_flush", flush, 0);
    check("rst_misalign", misalign_err, 0); check("rst_wb_regwrite", wb_regwrite, 0);
    check("rst_wb_memtoreg", wb_memtoreg, 0); check("rst_wb_readdata", wb_readdata, 0);
    check("rst_wb_alures", wb_alures, 0);   check("rst_wb_rd", wb_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      ref_mem[64'h1000 + 64'(i)] = (i == 3) ? 8'h80 : 8'h00;
      dev_mem[64'h1000 + 64'(i)] = (i == 3) ? 8'h80 : 8'h00;
    end
    mon_en = 1'b1;

    t = '0; t.alures = 64'h1234; t.rd = 5'd5; t.regwrite = 1'b1;
    issue(t, 0);
    t = '0; t.alures = 64'h1003; t.rd = 5'd7; t.regwrite = 1'b1; t.memtoreg = 1'b1;
    t.memread = 1'b1; t.func = 4'b0000;
    force_wait = 3;
    issue(t, 4);
    force_wait = -1;
    t = '0; t.alures = 64'h2002; t.rd2 = 64'hBEEF; t.memwrite = 1'b1; t.func = 4'b0001;
    issue(t, -1);
    t = '0; t.branch = 1'b1; t.func = 4'b0000; t.zero = 1'b1; t.addsum = 64'h400;
    issue(t, 0);
    t = '0; t.branch = 1'b1; t.func = 4'b0101; t.addsum = 64'h800;
    issue(t, 0);
    t = '0; t.alures = 64'h1002; t.func = 4'b0010; t.memread = 1'b1; t.memtoreg = 1'b1;
    t.regwrite = 1'b1; t.rd = 5'd9;
    issue(t, 0);

    for (int it = 0; it < 300; it++) begin
      kind = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      t = '0;
      t.zero = 1'($urandom); t.gt = 1'($urandom);
      if (kind <= 3) begin
        t.alures = r64(); t.rd = 5'($urandom); t.regwrite = 1'($urandom);
        t.func = 4'($urandom); t.rd2 = r64(); t.addsum = r64();
      end else if (kind <= 5) begin
        off = int'($urandom_range(0, 63)) & ~((1 << sz) - 1);
        t.alures = 64'h3000 + 64'(off);
        t.func = {1'b0, (sz == 2'b11) ? 1'b0 : 1'($urandom), sz};
        t.memread = 1'b1; t.memtoreg = 1'b1; t.regwrite = 1'b1;
        t.rd = 5'($urandom_range(1, 31));
      end else if (kind <= 7) begin
        off = int'($urandom_range(0, 63)) & ~((1 << sz) - 1);
        t.alures = 64'h3000 + 64'(off);
        t.func = {2'b00, sz}; t.rd2 = r64(); t.memwrite = 1'b1;
      end else if (kind == 8) begin
        sz = 2'($urandom_range(1, 3));
        off = int'($urandom_range(0, 62));
        if ((off & ((1 << sz) - 1)) == 0) off++;
        t.alures = 64'h3000 + 64'(off);
        t.func = {2'b00, sz};
        if ($urandom_range(0, 1) == 1) begin
          t.memread = 1'b1; t.memtoreg = 1'b1; t.regwrite = 1'b1;
          t.rd = 5'($urandom_range(1, 31));
        end else begin
          t.memwrite = 1'b1; t.rd2 = r64();
        end
      end else begin
        t.branch = 1'b1; t.func = {1'b0, 3'($urandom)}; t.addsum = r64(); t.alures = r64();
      end
      issue(t, (kind >= 4 && kind <= 7) ? -1 : 0);
    end

    // Reset while a request is outstanding.
    mon_en = 1'b0;
    t = '0; t.alures = 64'h3008; t.func = 4'b0011; t.memread = 1'b1; t.memtoreg = 1'b1;
    t.regwrite = 1'b1; t.rd = 5'd3;
    r = '0; r.addr = 64'h3008; r.be = 8'hFF;
    exp_req.push_back(r);
    force_wait = 10;
    drive(t);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dmem_req) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_event("req_before_reset");
    rst_n = 1'b0;
    #1;
    check("mid_rst_dmem_req", dmem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_wb_regwrite", wb_regwrite, 0);
    check("mid_rst_wb_rd", wb_rd, 0);
    check("mid_rst_wb_alures", wb_alures, 0);
    check("mid_rst_wb_readdata", wb_readdata, 0);
    check("mid_rst_wb_memtoreg", wb_memtoreg, 0);
    drive('0);
    force_wait = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_stall", stall, 0);
    check("post_rst_dmem_req", dmem_req, 0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      t = '0; t.alures = r64(); t.rd = 5'($urandom); t.regwrite = 1'b1;
      issue(t, 0);
    end
    mon_en = 1'b0;
    repeat (4) @(negedge clk);
    check("wb_queue_drained", exp_wb.size(), 0);
    check("req_queue_drained", exp_req.size(), 0);
    finish_run();
  end

endmodule
